// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM generator slice.
package pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_t;

  // Bits needed to hold 0..ticks-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/pwm_generator_if.sv
// Control and waveform signals of the PWM generator.
interface pwm_generator_if #(
  parameter int unsigned N = 8
);

  logic         ena;
  logic [N-1:0] duty;
  logic         out;
  logic         period_done;
  logic         running;

  modport master (
    output ena,
    output duty,
    input  out,
    input  period_done,
    input  running
  );

  modport slave (
    input  ena,
    input  duty,
    output out,
    output period_done,
    output running
  );

endinterface

// File: rtl/pulse_generator.sv
// Prescaler: emits a one-clock tick every TICKS enabled clocks.
module pulse_generator
  import pwm_pkg::*;
#(
  parameter int unsigned TICKS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  output logic tick
);

  localparam int unsigned W = cnt_width(TICKS);
  localparam logic [W-1:0] Last = W'(TICKS - 1);

  logic [W-1:0] pre_q;

  // With TICKS=1 the counter stays at zero and tick follows ena.
  assign tick = ena && (pre_q == Last);

  // Count enabled clocks, wrapping on tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else if (ena) begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// PWM generator with period-boundary duty shadowing and graceful stop.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int unsigned N              = 8,
  parameter int unsigned TICKS_PER_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  pwm_generator_if.slave  bus
);

  pwm_state_t   state_q;
  logic [N-1:0] cnt_q;
  logic [N-1:0] shd_q;
  logic         step;
  logic         running;
  logic         period_done;
  logic         pre_clr;

  assign running = (state_q == RUN);

  // Prescaler is held clear whenever the generator is idle.
  assign pre_clr = rst || !running;

  pulse_generator #(
    .TICKS (TICKS_PER_STEP)
  ) u_prescaler (
    .clk  (clk),
    .rst  (pre_clr),
    .ena  (running),
    .tick (step)
  );

  assign period_done = running && step && (cnt_q == '1);

  // Outputs decoded straight from registered state.
  always_comb begin
    bus.out         = running && (cnt_q < shd_q);
    bus.period_done = period_done;
    bus.running     = running;
  end

  // Run/idle sequencing, step counter and duty shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shd_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.ena) begin
            state_q <= RUN;
            cnt_q   <= '0;
            shd_q   <= bus.duty;
          end
        end
        RUN: begin
          if (step) begin
            cnt_q <= cnt_q + 1'b1;
          end
          // Duty and stop requests only act at the period boundary.
          if (period_done) begin
            shd_q <= bus.duty;
            if (!bus.ena) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator (N=4, TICKS_PER_STEP of 1 and 2).
module tb_pwm_generator;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pwm_generator_if #(.N(4)) bus ();
  pwm_generator_if #(.N(4)) bus2 ();

  pwm_generator #(
    .N              (4),
    .TICKS_PER_STEP (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pwm_generator #(
    .N              (4),
    .TICKS_PER_STEP (2)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Triangle source advanced by the PWM period strobe.
  logic       tri_rst;
  logic [3:0] tri_val_q;
  logic       tri_up_q;

  // Up/down triangle stepping once per period_done.
  always_ff @(posedge clk) begin
    if (tri_rst) begin
      tri_val_q <= '0;
      tri_up_q  <= 1'b1;
    end else if (bus.period_done) begin
      if (tri_up_q) begin
        if (tri_val_q == 4'hf) begin
          tri_up_q  <= 1'b0;
          tri_val_q <= tri_val_q - 1'b1;
        end else begin
          tri_val_q <= tri_val_q + 1'b1;
        end
      end else begin
        if (tri_val_q == 4'h0) begin
          tri_up_q  <= 1'b1;
          tri_val_q <= tri_val_q + 1'b1;
        end else begin
          tri_val_q <= tri_val_q - 1'b1;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Sample one DUT for a number of clocks; idx counts from the first sample.
  task automatic measure(input bit sel, input int clocks, output int highs, output int dones,
                         output int last_idx, output int runs);
    highs    = 0;
    dones    = 0;
    runs     = 0;
    last_idx = -1;
    for (int i = 0; i < clocks; i++) begin
      if (sel ? bus2.out : bus.out) highs++;
      if (sel ? bus2.running : bus.running) runs++;
      if (sel ? bus2.period_done : bus.period_done) begin
        dones++;
        last_idx = i;
      end
      step_clk();
    end
  endtask

  initial begin
    int h, d, li, r, h1;
    rst       = 1'b1;
    tri_rst   = 1'b1;
    bus.ena   = 1'b0;
    bus.duty  = '0;
    bus2.ena  = 1'b0;
    bus2.duty = '0;
    repeat (3) step_clk();
    check_eq("rst_out", bus.out, 0);
    check_eq("rst_running", bus.running, 0);
    check_eq("rst_pd", bus.period_done, 0);
    check_eq("rst_out2", bus2.out, 0);
    check_eq("rst_running2", bus2.running, 0);
    check_eq("rst_pd2", bus2.period_done, 0);
    rst = 1'b0;

    // TICKS=2, duty 5: 10 high, 22 low, strobe at clock 31 of 32.
    bus2.duty = 4'd5;
    bus2.ena  = 1'b1;
    step_clk();
    check_eq("t2_running", bus2.running, 1);
    for (int p = 0; p < 2; p++) begin
      measure(1'b1, 32, h, d, li, r);
      check_eq("t2_high", h, 10);
      check_eq("t2_dones", d, 1);
      check_eq("t2_done_idx", li, 31);
    end
    bus2.ena = 1'b0;

    // TICKS=1, duty 5.
    bus.duty = 4'd5;
    bus.ena  = 1'b1;
    step_clk();
    measure(1'b0, 16, h, d, li, r);
    check_eq("d5_high", h, 5);
    check_eq("d5_dones", d, 1);
    check_eq("d5_done_idx", li, 15);
    check_eq("d5_runs", r, 16);

    // Duty changes take effect one period later.
    bus.duty = 4'd0;
    measure(1'b0, 16, h, d, li, r);
    check_eq("d0_pending_high", h, 5);
    measure(1'b0, 16, h, d, li, r);
    check_eq("d0_high", h, 0);
    bus.duty = 4'd15;
    measure(1'b0, 16, h, d, li, r);
    check_eq("d15_pending_high", h, 0);
    measure(1'b0, 16, h, d, li, r);
    check_eq("d15_high", h, 15);
    check_eq("d15_done_idx", li, 15);

    // Mid-period change to 3 at clock 7.
    measure(1'b0, 7, h1, d, li, r);
    bus.duty = 4'd3;
    measure(1'b0, 9, h, d, li, r);
    check_eq("mid_cur_high", h1 + h, 15);
    measure(1'b0, 16, h, d, li, r);
    check_eq("mid_next_high", h, 3);

    // Drop ena at clock 5: finish the period, then idle.
    measure(1'b0, 5, h, d, li, r);
    bus.ena = 1'b0;
    measure(1'b0, 11, h, d, li, r);
    check_eq("stop_runs", r, 11);
    check_eq("stop_dones", d, 1);
    check_eq("stop_done_idx", li, 10);
    check_eq("stop_running", bus.running, 0);
    check_eq("stop_out", bus.out, 0);
    measure(1'b0, 20, h, d, li, r);
    check_eq("idle_high", h, 0);
    check_eq("idle_dones", d, 0);
    check_eq("idle_runs", r, 0);

    // Reset at clock 9 aborts the period without a strobe.
    bus.duty = 4'd7;
    bus.ena  = 1'b1;
    step_clk();
    measure(1'b0, 9, h, d, li, r);
    check_eq("pre_rst_high", h, 7);
    check_eq("pre_rst_dones", d, 0);
    rst = 1'b1;
    step_clk();
    check_eq("abort_out", bus.out, 0);
    check_eq("abort_running", bus.running, 0);
    check_eq("abort_pd", bus.period_done, 0);
    rst = 1'b0;
    step_clk();
    check_eq("restart_running", bus.running, 1);
    measure(1'b0, 16, h, d, li, r);
    check_eq("restart_high", h, 7);
    check_eq("restart_done_idx", li, 15);

    // Triangle fed from period_done; high time follows the latched value.
    tri_rst  = 1'b0;
    bus.duty = tri_val_q;
    for (int p = 0; p < 5; p++) begin
      h = 0;
      d = 0;
      for (int i = 0; i < 16; i++) begin
        if (bus.out) h++;
        if (bus.period_done) d++;
        step_clk();
        bus.duty = tri_val_q;
      end
      check_eq("tri_high", h, (p == 0) ? 7 : p - 1);
      check_eq("tri_dones", d, 1);
      check_eq("tri_value", tri_val_q, p + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
